// File: rtl/vga_timing_generator.sv
// 640x480@60 VGA raster timing: pixel strobe, x/y counters, syncs and blanking.
// Define VGA_TIMING_LOOKAHEAD_EN to delay HSYNC/VSYNC/VIDEO_ON by one pixel.
module vga_timing_generator #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       CLK_IN,
  input  logic       RST_N,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       VIDEO_ON,
  output logic       PIXEL_TICK,
  output logic       FRAME_START
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [9:0]       h_nxt, v_nxt;
  logic             hs_nxt, vs_nxt, vo_nxt;

  assign tick = (div == DIV_LAST);

  // Outputs are derived from the post-tick counter values so they line up with x/y.
  always_comb begin
    h_nxt = x + 10'd1;
    v_nxt = y;
    if (x == H_LAST) begin
      h_nxt = 10'd0;
      v_nxt = (y == V_LAST) ? 10'd0 : y + 10'd1;
    end
    hs_nxt = !((h_nxt >= HS_START) && (h_nxt < HS_END));
    vs_nxt = !((v_nxt >= VS_START) && (v_nxt < VS_END));
    vo_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      div         <= '0;
      x           <= H_LAST;
      y           <= V_LAST;
      PIXEL_TICK  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      div         <= tick ? '0 : div + DIV_W'(1);
      PIXEL_TICK  <= tick;
      FRAME_START <= tick && (h_nxt == 10'd0) && (v_nxt == 10'd0);
      if (tick) begin
        x <= h_nxt;
        y <= v_nxt;
      end
    end
  end

`ifdef VGA_TIMING_LOOKAHEAD_EN
  // Extra stage absorbs the one-pixel memory read latency downstream.
  logic hs_d1, vs_d1, vo_d1;

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
      vo_d1    <= 1'b0;
      HSYNC    <= 1'b1;
      VSYNC    <= 1'b1;
      VIDEO_ON <= 1'b0;
    end else if (tick) begin
      hs_d1    <= hs_nxt;
      vs_d1    <= vs_nxt;
      vo_d1    <= vo_nxt;
      HSYNC    <= hs_d1;
      VSYNC    <= vs_d1;
      VIDEO_ON <= vo_d1;
    end
  end
`else
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      HSYNC    <= 1'b1;
      VSYNC    <= 1'b1;
      VIDEO_ON <= 1'b0;
    end else if (tick) begin
      HSYNC    <= hs_nxt;
      VSYNC    <= vs_nxt;
      VIDEO_ON <= vo_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: default 640x480 timing plus a tiny raster
// for full-frame checks, both against an arithmetic model of the raster.
module tb_vga_timing_generator;

`ifdef VGA_TIMING_LOOKAHEAD_EN
  localparam bit LA = 1'b1;
`else
  localparam bit LA = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       pt;
    logic       fs;
  } vga_t;

  logic       CLK_IN = 1'b0;
  logic       rst_a, rst_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       hs_a, vs_a, vo_a, pt_a, fs_a;
  logic       hs_b, vs_b, vo_b, pt_b, fs_b;

  int n_err = 0;
  int n_chk = 0;

  always #5 CLK_IN = ~CLK_IN;

  vga_timing_generator #(.CLK_DIV(2)) dut_a (
    .CLK_IN(CLK_IN), .RST_N(rst_a), .x(x_a), .y(y_a), .HSYNC(hs_a), .VSYNC(vs_a),
    .VIDEO_ON(vo_a), .PIXEL_TICK(pt_a), .FRAME_START(fs_a)
  );

  vga_timing_generator #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(3)
  ) dut_b (
    .CLK_IN(CLK_IN), .RST_N(rst_b), .x(x_b), .y(y_b), .HSYNC(hs_b), .VSYNC(vs_b),
    .VIDEO_ON(vo_b), .PIXEL_TICK(pt_b), .FRAME_START(fs_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  // Raster position after k ticks, as a linear pixel index into the frame.
  function automatic int pidx(int k, int n);
    return (k == 0) ? n - 1 : (k - 1) % n;
  endfunction

  // Expected outputs c clock edges after reset release (c=0: in/just out of reset).
  function automatic vga_t ref_out(int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb, int dv, int c);
    vga_t r;
    int ht, vt, k, p, fk, fh, fv;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    k  = c / dv;
    p  = pidx(k, ht * vt);
    r.x  = 10'(p % ht);
    r.y  = 10'(p / ht);
    r.pt = (c > 0) && (c % dv == 0);
    r.fs = r.pt && (p == 0);
    fk = (LA && k > 0) ? k - 1 : k;
    p  = pidx(fk, ht * vt);
    fh = p % ht;
    fv = p / ht;
    r.vo = (fh < hv) && (fv < vv);
    r.hs = !((fh >= hv + hf) && (fh < hv + hf + hsw));
    r.vs = !((fv >= vv + vf) && (fv < vv + vf + vsw));
    return r;
  endfunction

  function automatic vga_t ref_a(int c);
    return ref_out(640, 16, 96, 48, 480, 10, 2, 33, 2, c);
  endfunction

  function automatic vga_t ref_b(int c);
    return ref_out(8, 2, 3, 2, 5, 1, 2, 2, 3, c);
  endfunction

  task automatic cmp_all(input string pfx, input vga_t o, input vga_t e);
    chk({pfx, ".x"}, 32'(o.x), 32'(e.x));
    chk({pfx, ".y"}, 32'(o.y), 32'(e.y));
    chk({pfx, ".hsync"}, 32'(o.hs), 32'(e.hs));
    chk({pfx, ".vsync"}, 32'(o.vs), 32'(e.vs));
    chk({pfx, ".video_on"}, 32'(o.vo), 32'(e.vo));
    chk({pfx, ".pixel_tick"}, 32'(o.pt), 32'(e.pt));
    chk({pfx, ".frame_start"}, 32'(o.fs), 32'(e.fs));
  endtask

  vga_t obs_a, obs_b;
  assign obs_a = '{x: x_a, y: y_a, hs: hs_a, vs: vs_a, vo: vo_a, pt: pt_a, fs: fs_a};
  assign obs_b = '{x: x_b, y: y_b, hs: hs_b, vs: vs_b, vo: vo_b, pt: pt_b, fs: fs_b};

  initial begin
    int c, len, hs_low, vo_cnt, pt_cnt, fs_cnt, last_fs;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(posedge CLK_IN);
    #1 cmp_all("rst_a", obs_a, ref_a(0));
    cmp_all("rst_b", obs_b, ref_b(0));

    // Default timing: runs of random length cut short by a mid-cycle async reset.
    for (int r = 0; r < 3; r++) begin
      @(negedge CLK_IN);
      rst_a  = 1'b1;
      c      = 0;
      hs_low = 0;
      len    = int'($urandom_range(1700, 3400));
      for (int i = 0; i < len; i++) begin
        @(posedge CLK_IN);
        c++;
        #1 cmp_all("run_a", obs_a, ref_a(c));
        if (pt_a && y_a == 10'd0 && !hs_a) hs_low++;
      end
      chk("hsync_low_line0", 32'(hs_low), 32'd96);
      @(posedge CLK_IN);
      #3 rst_a = 1'b0;
      #1 cmp_all("async_rst_a", obs_a, ref_a(0));
      repeat (int'($urandom_range(1, 4))) @(posedge CLK_IN);
      #1 cmp_all("hold_rst_a", obs_a, ref_a(0));
    end

    // Tiny raster (15x10, divide by 3): whole frames.
    @(negedge CLK_IN);
    rst_b   = 1'b1;
    c       = 0;
    vo_cnt  = 0;
    pt_cnt  = 0;
    fs_cnt  = 0;
    last_fs = -1;
    for (int i = 0; i < 3 * 450 + 5; i++) begin
      @(posedge CLK_IN);
      c++;
      #1 cmp_all("run_b", obs_b, ref_b(c));
      if (fs_b) begin
        fs_cnt++;
        if (last_fs >= 0) chk("frame_start_gap", 32'(c - last_fs), 32'd450);
        last_fs = c;
      end
      if (c > 450 && c <= 900) begin
        if (pt_b) pt_cnt++;
        if (pt_b && vo_b) vo_cnt++;
      end
    end
    chk("video_on_ticks_frame", 32'(vo_cnt), 32'd40);
    chk("pixel_ticks_frame", 32'(pt_cnt), 32'd150);
    chk("frame_start_count", 32'(fs_cnt), 32'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
